// File: rtl/ifetch_unit.sv
// Instruction fetch front end: one outstanding bus request, a one-entry
// instruction buffer for hazard stalls, and redirect handling while a request is in flight.
module ifetch_unit #(
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  PCWrite,
  input  logic        PCSel,
  input  logic [63:0] pc_target,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        imem_wait,
  output logic [63:0] pc_f,
  output logic [31:0] instr_f
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [63:0] redir_pc, redir_nxt;
  logic [31:0] ibuf, ibuf_nxt;
  logic        advance;
  logic [63:0] seq_pc;

  assign advance = (PCWrite == 2'b00);
  assign seq_pc  = pc + 64'd4;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_FETCH;
      pc       <= PCINIT;
      redir_pc <= 64'd0;
      ibuf     <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redir_pc <= redir_nxt;
      ibuf     <= ibuf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    redir_nxt = redir_pc;
    ibuf_nxt  = ibuf;
    case (state)
      S_FETCH: begin
        if (iresp_data_ok) begin
          if (advance) begin
            pc_nxt = PCSel ? pc_target : seq_pc;
          end else begin
            ibuf_nxt  = iresp_data;
            state_nxt = S_HOLD;
          end
        end else if (PCSel) begin
          redir_nxt = pc_target;
          state_nxt = S_DROP;
        end
      end
      // Redirects are ignored while stalled; PCSel is held until the stall lifts.
      S_HOLD: begin
        if (advance) begin
          pc_nxt    = PCSel ? pc_target : seq_pc;
          state_nxt = S_FETCH;
        end
      end
      S_DROP: begin
        if (PCSel) redir_nxt = pc_target;
        if (iresp_data_ok) begin
          pc_nxt    = PCSel ? pc_target : redir_pc;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // imem_wait must not look at PCWrite, or a loop forms through the hazard unit.
  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = pc;
    imem_wait  = 1'b1;
    instr_f    = 32'd0;
    pc_f       = pc;
    if (resetn) begin
      case (state)
        S_FETCH: begin
          ireq_valid = 1'b1;
          imem_wait  = ~iresp_data_ok;
          instr_f    = iresp_data;
        end
        S_HOLD: begin
          imem_wait = 1'b0;
          instr_f   = ibuf;
        end
        S_DROP: begin
          ireq_valid = 1'b1;
          imem_wait  = 1'b1;
        end
        default: begin
          ireq_valid = 1'b0;
          imem_wait  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: expected request addresses are queued as
// each scenario is driven and popped when the DUT issues the request.
module tb_ifetch_unit;

  logic        clk;
  logic        resetn;
  logic [1:0]  PCWrite;
  logic        PCSel;
  logic [63:0] pc_target;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        ireq_valid, imem_wait;
  logic [63:0] ireq_addr, pc_f;
  logic [31:0] instr_f;
  logic        w_ireq_valid, w_imem_wait;
  logic [63:0] w_ireq_addr, w_pc_f;
  logic [31:0] w_instr_f;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  ifetch_unit u_dut (
    .clk(clk), .resetn(resetn), .PCWrite(PCWrite), .PCSel(PCSel), .pc_target(pc_target),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .imem_wait(imem_wait), .pc_f(pc_f), .instr_f(instr_f)
  );

  ifetch_unit #(.PCINIT(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .resetn(resetn), .PCWrite(PCWrite), .PCSel(PCSel), .pc_target(pc_target),
    .ireq_valid(w_ireq_valid), .ireq_addr(w_ireq_addr), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .imem_wait(w_imem_wait), .pc_f(w_pc_f), .instr_f(w_instr_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    PCWrite = 2'b00; PCSel = 1'b0; pc_target = 64'd0;
    iresp_data_ok = 1'b0; iresp_data = 32'd0;
  endtask

  // Leaves the bench #1 after a negedge with reset just released.
  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF; PCSel = 1'b1; pc_target = 64'h123;
    exp_q.push_back(64'h8000_0000);
    #1;
    total++; if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ireq_valid); end
    total++; if (imem_wait !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b exp=1", imem_wait); end
    total++; if (instr_f !== 32'd0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_f); end
    total++; if (pc_f !== 64'h8000_0000) begin bad++; $display("FAIL rst_pcf got=%h exp=80000000", pc_f); end
    total++; if (w_pc_f !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL rst_wrap_pcf got=%h", w_pc_f); end
    @(negedge clk);
    @(negedge clk);
    total++; if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b exp=0", ireq_valid); end
    idle_inputs();
    resetn = 1'b1;
    #1;
    e = exp_q.pop_front();
    total++; if (ireq_valid !== 1'b1) begin bad++; $display("FAIL rst_first_valid got=%b exp=1", ireq_valid); end
    total++; if (ireq_addr !== e) begin bad++; $display("FAIL rst_first_addr got=%h exp=%h", ireq_addr, e); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(64'h8000_0000 + 64'(4 * i));
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      total++; if (ireq_valid !== 1'b1 || ireq_addr !== e) begin
        bad++; $display("FAIL stream_req%0d got=%b/%h exp=1/%h", i, ireq_valid, ireq_addr, e);
      end
      total++; if (imem_wait !== 1'b1) begin bad++; $display("FAIL stream_wait_pend%0d got=%b exp=1", i, imem_wait); end
      cyc();
      iresp_data_ok = 1'b1; iresp_data = 32'h0000_0100 + 32'(i);
      #1;
      total++; if (imem_wait !== 1'b0) begin bad++; $display("FAIL stream_wait_ok%0d got=%b exp=0", i, imem_wait); end
      total++; if (instr_f !== 32'h0000_0100 + 32'(i) || pc_f !== e) begin
        bad++; $display("FAIL stream_instr%0d got=%h@%h exp=%h@%h", i, instr_f, pc_f, 32'h100 + 32'(i), e);
      end
      cyc();
      iresp_data_ok = 1'b0;
      #1;
    end
  endtask

  task automatic test_stall();
    do_reset();
    exp_q.push_back(64'h8000_0004);
    cyc();
    iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013; PCWrite = 2'b11;
    #1;
    total++; if (imem_wait !== 1'b0 || instr_f !== 32'h13) begin
      bad++; $display("FAIL stall_ok got=%b/%h exp=0/00000013", imem_wait, instr_f);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      iresp_data_ok = 1'b0; iresp_data = 32'hFFFF_FFFF;
      PCWrite = (i == 3) ? 2'b00 : 2'b11;
      #1;
      total++; if (ireq_valid !== 1'b0 || imem_wait !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d valid/wait got=%b/%b exp=0/0", i, ireq_valid, imem_wait);
      end
      total++; if (instr_f !== 32'h13 || pc_f !== 64'h8000_0000) begin
        bad++; $display("FAIL stall_buf%0d got=%h@%h exp=00000013@80000000", i, instr_f, pc_f);
      end
    end
    cyc();
    #1;
    e = exp_q.pop_front();
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== e) begin
      bad++; $display("FAIL stall_resume got=%b/%h exp=1/%h", ireq_valid, ireq_addr, e);
    end
  endtask

  task automatic test_redirect_hit();
    do_reset();
    exp_q.push_back(64'h8000_0100);
    cyc();
    iresp_data_ok = 1'b1; iresp_data = 32'h0000_006F; PCSel = 1'b1; pc_target = 64'h8000_0100;
    #1;
    total++; if (imem_wait !== 1'b0) begin bad++; $display("FAIL hit_wait got=%b exp=0", imem_wait); end
    cyc();
    iresp_data_ok = 1'b0; PCSel = 1'b0;
    #1;
    e = exp_q.pop_front();
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== e || pc_f !== e) begin
      bad++; $display("FAIL hit_target got=%b/%h exp=1/%h", ireq_valid, ireq_addr, e);
    end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    for (int j = 0; j < 4; j++) begin
      cyc(); iresp_data_ok = 1'b1;
      cyc(); iresp_data_ok = 1'b0;
    end
    #1;
    exp_q.push_back(64'h8000_0010);
    exp_q.push_back(64'h8000_0300);
    e = exp_q.pop_front();
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== e) begin
      bad++; $display("FAIL miss_req got=%b/%h exp=1/%h", ireq_valid, ireq_addr, e);
    end
    for (int c = 1; c <= 5; c++) begin
      cyc();
      PCSel = (c == 1 || c == 3);
      pc_target = (c == 1) ? 64'h8000_0200 : (c == 3) ? 64'h8000_0300 : 64'h0;
      iresp_data_ok = (c == 5); iresp_data = 32'hBADB_AD00;
      #1;
      total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010 || imem_wait !== 1'b1) begin
        bad++; $display("FAIL miss_hold%0d got=%b/%h/%b exp=1/80000010/1", c, ireq_valid, ireq_addr, imem_wait);
      end
    end
    cyc();
    iresp_data_ok = 1'b0; PCSel = 1'b0;
    #1;
    e = exp_q.pop_front();
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== e) begin
      bad++; $display("FAIL miss_target got=%b/%h exp=1/%h", ireq_valid, ireq_addr, e);
    end
  endtask

  task automatic test_drop_same_cycle();
    do_reset();
    exp_q.push_back(64'h8000_0500);
    cyc();
    PCSel = 1'b1; pc_target = 64'h8000_0400;
    cyc();
    iresp_data_ok = 1'b1; pc_target = 64'h8000_0500;
    #1;
    total++; if (imem_wait !== 1'b1) begin bad++; $display("FAIL drop_ok_wait got=%b exp=1", imem_wait); end
    cyc();
    iresp_data_ok = 1'b0; PCSel = 1'b0;
    #1;
    e = exp_q.pop_front();
    total++; if (ireq_addr !== e) begin bad++; $display("FAIL drop_latest got=%h exp=%h", ireq_addr, e); end
  endtask

  task automatic test_reset_mid_drop();
    do_reset();
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    cyc();
    PCSel = 1'b1; pc_target = 64'h8000_0600;
    cyc();
    PCSel = 1'b0; iresp_data = 32'h1234_5678;
    #1;
    total++; if (ireq_valid !== 1'b1 || imem_wait !== 1'b1) begin
      bad++; $display("FAIL mid_drop_pre got=%b/%b exp=1/1", ireq_valid, imem_wait);
    end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (ireq_valid !== 1'b0 || imem_wait !== 1'b1 || pc_f !== 64'h8000_0000 || instr_f !== 32'd0) begin
      bad++; $display("FAIL mid_drop_rst got=%b/%b/%h/%h exp=0/1/80000000/0", ireq_valid, imem_wait, pc_f, instr_f);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    e = exp_q.pop_front();
    total++; if (ireq_valid !== 1'b1 || ireq_addr !== e) begin
      bad++; $display("FAIL mid_drop_first got=%b/%h exp=1/%h", ireq_valid, ireq_addr, e);
    end
    cyc();
    iresp_data_ok = 1'b1;
    cyc();
    iresp_data_ok = 1'b0;
    #1;
    e = exp_q.pop_front();
    total++; if (ireq_addr !== e) begin bad++; $display("FAIL mid_drop_next got=%h exp=%h", ireq_addr, e); end
  endtask

  task automatic test_wrap();
    do_reset();
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0);
    e = exp_q.pop_front();
    total++; if (w_ireq_valid !== 1'b1 || w_ireq_addr !== e) begin
      bad++; $display("FAIL wrap_first got=%b/%h exp=1/%h", w_ireq_valid, w_ireq_addr, e);
    end
    cyc();
    iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
    #1;
    total++; if (w_imem_wait !== 1'b0 || w_instr_f !== 32'h13) begin
      bad++; $display("FAIL wrap_ok got=%b/%h exp=0/00000013", w_imem_wait, w_instr_f);
    end
    cyc();
    iresp_data_ok = 1'b0;
    #1;
    e = exp_q.pop_front();
    total++; if (w_ireq_valid !== 1'b1 || w_ireq_addr !== e) begin
      bad++; $display("FAIL wrap_next got=%b/%h exp=1/%h", w_ireq_valid, w_ireq_addr, e);
    end
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_hit();
    test_redirect_miss();
    test_drop_same_cycle();
    test_reset_mid_drop();
    test_wrap();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: PCINIT, default 64'h8000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: PCWrite  input  2  PC control code from the hazard unit: 2'b00 advance; any other value holds the PC.
REQ-005 Port: PCSel  input  1  redirect request from the branch/jump resolution logic.
REQ-006 Port: pc_target  input  64  redirect target, valid when PCSel=1.
REQ-007 Port: ireq_valid  output  1  instruction-bus request valid.
REQ-008 Port: ireq_addr  output  64  instruction-bus request address.
REQ-009 Port: iresp_data_ok  input  1  instruction-bus response valid, one-cycle pulse per request.
REQ-010 Port: iresp_data  input  32  instruction word, valid when iresp_data_ok=1.
REQ-011 Port: imem_wait  output  1  fetch not complete this cycle; drives the hazard unit.
REQ-012 Port: pc_f  output  64  PC of the instruction presented on instr_f.
REQ-013 Port: instr_f  output  32  fetched instruction, meaningful when imem_wait=0.

Function
REQ-014 The block SHALL implement three states: FETCH (request outstanding), HOLD (instruction buffered, PC stalled), and DROP (stale request outstanding, redirect pending).
REQ-015 The block SHALL have at most one outstanding bus request; in FETCH and DROP, ireq_valid=1 and ireq_addr stays constant until iresp_data_ok.
REQ-016 In FETCH, ireq_addr=pc; imem_wait=~iresp_data_ok; instr_f=iresp_data combinationally; pc_f=pc.
REQ-017 In FETCH with iresp_data_ok=1 and PCWrite=00: next pc=PCSel ? pc_target : pc+4 (64-bit wrap); the block SHALL stay in FETCH and issue the new request the next cycle.
REQ-018 In FETCH with iresp_data_ok=1 and PCWrite!=00: the block SHALL latch iresp_data into the instruction buffer, hold pc, and enter HOLD.
REQ-019 In FETCH with iresp_data_ok=0 and PCSel=1: the block SHALL latch pc_target into redir_pc and enter DROP; pc is unchanged.
REQ-020 In HOLD: ireq_valid=0, imem_wait=0, instr_f=buffer, pc_f=pc; on PCWrite=00, next pc=PCSel ? pc_target : pc+4 and the block SHALL enter FETCH; otherwise it stays in HOLD.
REQ-021 In HOLD with PCSel=1 and PCWrite!=00, the block SHALL ignore the redirect; the hazard unit guarantees that PCSel persists until PCWrite=00.
REQ-022 In DROP: ireq_valid=1, ireq_addr=old pc, imem_wait=1; the response data SHALL be discarded.
REQ-023 In DROP, a further PCSel=1 SHALL overwrite redir_pc, with the latest target winning, including in the cycle of iresp_data_ok.
REQ-024 In DROP with iresp_data_ok=1: pc<=(PCSel ? pc_target : redir_pc) and the block SHALL enter FETCH; the next request goes out the following cycle.
REQ-025 pc_target SHALL be used verbatim; misaligned targets are not checked here.
REQ-026 imem_wait SHALL depend combinationally only on state and iresp_data_ok, and never on PCWrite, so that no combinational loop forms through the hazard unit.

Reset
REQ-027 While resetn=0: state=FETCH, pc=PCINIT, redir_pc=0, buffer=0, ireq_valid=0, imem_wait=1, pc_f=PCINIT, instr_f=0.
REQ-028 Reset asserted mid-request SHALL abandon all state immediately; the bus is reset together with the block, so no stale response is expected.
REQ-029 In the first cycle after resetn rises, ireq_valid=1 and ireq_addr=PCINIT.

Verification
REQ-030 Streaming: reset release, memory returns data_ok one cycle after each request, PCWrite=00 -> requests to 8000_0000, 8000_0004, 8000_0008; imem_wait=0 on each data_ok cycle.
REQ-031 Stall: data_ok with instr 0x00000013 while PCWrite=11 for 3 cycles -> HOLD, ireq_valid=0, instr_f=0x00000013 stable, pc_f constant; after PCWrite=00, next request is at pc+4.
REQ-032 Redirect on hit: data_ok, PCSel=1, target 8000_0100, PCWrite=00 -> next ireq_addr=8000_0100.
REQ-033 Redirect during miss: request at 8000_0010 pending; PCSel=1 with target 8000_0200, then target 8000_0300 two cycles later; data_ok after 5 cycles -> ireq_addr held at 8000_0010 throughout, response discarded with imem_wait=1, next request at 8000_0300.
REQ-034 Async reset pulse mid-DROP -> outputs match REQ-027 within the same cycle; the first post-reset request is at PCINIT.
REQ-035 Wrap: PCINIT=64'hFFFF_FFFF_FFFF_FFFC, data_ok with PCWrite=00 -> next ireq_addr=0.
